// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: multi-cycle wide adder controller.
// It sequences one SLICE_W-bit two-level carry-lookahead slice across NSLICE
// slices, one slice per clock. The slice carry is chained through a register.
// Optional build macro: CLA_SUB_EN adds a 'sub' input for A - B.
//   When sub=1, B is stored inverted and the initial carry is forced to 1.
module cla_serial_add_ctrl #(
  parameter int SLICE_W = 16,
  parameter int NSLICE  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SLICE_W*NSLICE-1:0]   a,
  input  logic [SLICE_W*NSLICE-1:0]   b,
  input  logic                        cin,
`ifdef CLA_SUB_EN
  input  logic                        sub,
`endif
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic [SLICE_W*NSLICE-1:0]   sum,
  output logic                        cout,
  output logic                        ovf,
  output logic                        all_prop
);

  localparam int TOTAL_W = SLICE_W * NSLICE;
  localparam int IDX_W   = $clog2(NSLICE);
  localparam int NGRP    = SLICE_W / 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic               pg;
    logic               c_msb;
    logic               co;
    logic [SLICE_W-1:0] s;
  } slice_res_t;

  // One slice: 4-bit CLA groups, then a second lookahead level across groups.
  function automatic slice_res_t cla_slice(input logic [SLICE_W-1:0] x,
                                           input logic [SLICE_W-1:0] y,
                                           input logic               ci);
    slice_res_t         r;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] c;
    logic [NGRP-1:0]    gg;
    logic [NGRP-1:0]    pgv;
    logic               slice_gg;
    p = x ^ y;
    g = x & y;
    for (int k = 0; k < NGRP; k++) begin
      gg[k]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
               (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
               (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pgv[k] = &p[4*k +: 4];
    end
    c    = '0;
    c[0] = ci;
    // Group carry-ins from the second lookahead level
    for (int k = 1; k < NGRP; k++) begin
      c[4*k] = gg[k-1] | (pgv[k-1] & c[4*k-4]);
    end
    // Carries inside each group
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    slice_gg = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      slice_gg = gg[k] | (pgv[k] & slice_gg);
    end
    r.s     = p ^ c;
    r.pg    = &p;
    r.co    = slice_gg | (r.pg & ci);
    r.c_msb = c[SLICE_W-1];
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               prop_acc_q, prop_acc_d;
  logic [TOTAL_W-1:0] a_q, a_d;
  logic [TOTAL_W-1:0] b_q, b_d;
  logic [TOTAL_W-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               all_prop_q, all_prop_d;

  logic [TOTAL_W-1:0] b_load;
  logic               c_load;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  slice_res_t         res;

`ifdef CLA_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // Select the active operand slice and run it through the CLA slice
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx_q == IDX_W'(s)) begin
        a_sl = a_q[s*SLICE_W +: SLICE_W];
        b_sl = b_q[s*SLICE_W +: SLICE_W];
      end
    end
    res = cla_slice(a_sl, b_sl, carry_q);
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    prop_acc_d = prop_acc_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    all_prop_d = all_prop_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d        = a;
          b_d        = b_load;
          carry_d    = c_load;
          idx_d      = '0;
          prop_acc_d = 1'b1;
          state_d    = S_RUN;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_RUN: begin
        for (int s = 0; s < NSLICE; s++) begin
          if (idx_q == IDX_W'(s)) begin
            sum_d[s*SLICE_W +: SLICE_W] = res.s;
          end
        end
        carry_d    = res.co;
        prop_acc_d = prop_acc_q & res.pg;
        if (idx_q == IDX_W'(NSLICE-1)) begin
          cout_d     = res.co;
          ovf_d      = res.c_msb ^ res.co;
          all_prop_d = prop_acc_q & res.pg;
          state_d    = S_DONE;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      prop_acc_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      all_prop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      prop_acc_q <= prop_acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      all_prop_q <= all_prop_d;
    end
  end

  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign ovf      = ovf_q;
  assign all_prop = all_prop_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Bench for cla_serial_add_ctrl (default build, SLICE_W=16, NSLICE=4).
// Expected results are queued on issue and compared when done pulses.
module tb_cla_serial_add_ctrl;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         ap;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         cin_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
`ifdef CLA_SUB_EN
  logic         sub_i = 1'b0;
`endif
  logic         ready, busy, done, cout, ovf, all_prop;
  logic [W-1:0] sum;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  cla_serial_add_ctrl #(.SLICE_W(16), .NSLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a_i), .b(b_i), .cin(cin_i),
`ifdef CLA_SUB_EN
    .sub(sub_i),
`endif
    .ready(ready), .busy(busy), .done(done),
    .sum(sum), .cout(cout), .ovf(ovf), .all_prop(all_prop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide addition
  function automatic vec_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    vec_t     v;
    logic [W:0] r;
    r    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    v.a  = av;
    v.b  = bv;
    v.cin = cv;
    v.s  = r[W-1:0];
    v.co = r[W];
    v.ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    v.ap = &(av ^ bv);
    return v;
  endfunction

  // Scoreboard: compare each done pulse against the oldest pending result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with no pending operation");
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("sum", sum, e.s);
        check("cout", 64'(cout), 64'(e.co));
        check("ovf", 64'(ovf), 64'(e.ov));
        check("all_prop", 64'(all_prop), 64'(e.ap));
      end
    end
  end

  task automatic issue(input vec_t v, input bit sync);
    if (sync) @(negedge clk);
    a_i   = v.a;
    b_i   = v.b;
    cin_i = v.cin;
    start = 1'b1;
    check("accept_ready", 64'(ready), 64'd1);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = {$urandom, $urandom};
    b_i   = {$urandom, $urandom};
    cin_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n;
    int bc;
    n  = 0;
    bc = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!done && n < 20);
    check("latency", 64'(n), 64'd5);
    check("busy_cycles", 64'(bc), 64'd4);
    check("done_ready", 64'(ready), 64'd1);
  endtask

  initial begin
    vec_t v;
    int   n;
    int   bc;
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_all_prop", 64'(all_prop), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table of directed vectors
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i], 1'b1);
      wait_done();
    end

    // Asynchronous reset mid-cycle while results are held (last op left cout/ovf=1)
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum", sum, 64'd0);
    check("async_rst_cout", 64'(cout), 64'd0);
    check("async_rst_ovf", 64'(ovf), 64'd0);
    check("async_rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Random operands against the reference
    for (int i = 0; i < 6; i++) begin
      v = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      issue(v, 1'b1);
      wait_done();
    end

    // start held through RUN with changing operands: ignored
    v = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    issue(v, 1'b1);
    start = 1'b1;
    n  = 0;
    bc = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      a_i = {$urandom, $urandom};
      b_i = {$urandom, $urandom};
      if (n == 4) start = 1'b0;
    end while (!done && n < 20);
    start = 1'b0;
    check("hold_latency", 64'(n), 64'd5);
    check("hold_busy_cycles", 64'(bc), 64'd4);
    repeat (3) @(negedge clk);

    // Back-to-back: new start in the DONE cycle
    issue(tbl[0], 1'b1);
    wait_done();
    issue(tbl[3], 1'b0);
    check("b2b_no_idle_busy", 64'(busy), 64'd1);
    wait_done();

    // Reset in the middle of an operation (idx=2)
    v = model(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(v, 1'b1);
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sum", sum, 64'd0);
    check("midrst_all_prop", 64'(all_prop), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_done", 64'(done), 64'd0);
    end
    issue(tbl[4], 1'b1);
    wait_done();

`ifdef CLA_SUB_EN
    // Subtraction: 5 - 7 and 7 - 5
    sub_i = 1'b1;
    v = '{64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    issue(v, 1'b1);
    wait_done();
    v = '{64'd7, 64'd5, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0};
    issue(v, 1'b1);
    wait_done();
    sub_i = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
